cp0_exc_handler: RTL and testbench
==================================

Name: cp0_exc_handler

Overview:
- Coprocessor-0 exception/interrupt sink for the 5-stage MIPS pipeline. It is the receiving end of the 5-bit ExcCode bus produced by the execute-stage arithmetic unit and carried to the memory stage.
- Holds SR(12), Cause(13), EPC(14) and PRId(15).
- Arbitrates hardware interrupts against synchronous exceptions and raises a single flush/redirect request to the pipeline.
- Services mfc0/mtc0/eret.

Parameters:
- PRID_VALUE, 32'h0000_4D4D, constant returned on reads of register 15.
- HWINT_W, 6, number of hardware interrupt lines; fixed to 6, IP/IM fields are bits [15:10].

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable (memory stage).
- PC_M  input  32  PC of the instruction in the memory stage.
- BD_M  input  1  memory-stage instruction sits in a branch delay slot.
- ExcCode_M  input  5  exception code from upstream (0 = none; 4 AdEL, 5 AdES, 12 Ov, others per MIPS).
- HWInt  input  6  level-sensitive hardware interrupt lines.
- EXLClr  input  1  eret in memory stage.
- IntReq  output  1  flush pipeline and redirect fetch to the handler.
- EPC  output  32  current EPC, used as the eret target.
- DOut  output  32  mfc0 read data.

Behaviour:
- Reset (reset=0, async): SR=0, Cause=0, EPC=0 (and BadVAddr=0 when the optional feature is compiled in).
  - Outputs during reset: IntReq=0, EPC=0, DOut per A1 with zeroed registers.
  - Reset deassert is sampled synchronously; the first update is on the next edge.
- SR fields: IM=[15:10], EXL=[1], IE=[0]. All other bits read 0 and are not writable.
- Cause fields: BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0. Cause is read-only to mtc0.
- Cause.IP is loaded from HWInt every cycle, unconditionally.
- IntReq is combinational:
  - int_req = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL
  - exc_req = (ExcCode_M != 0) & ~SR.EXL
  - IntReq = int_req | exc_req
- Priority: interrupt over exception. On an entry edge (IntReq=1):
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : ExcCode_M.
  - Cause.BD <= BD_M.
  - EPC <= BD_M ? {PC_M[31:2],2'b00} - 4 : {PC_M[31:2],2'b00}.
  - The latency from a request to EXL visible is exactly 1 cycle. IntReq therefore drops the cycle after entry and stays low while EXL=1.
- mtc0:
  - Applied on the edge when WE=1 and IntReq=0; suppressed when IntReq=1 (entry wins).
  - A2=12 writes IM/EXL/IE only.
  - A2=14 writes EPC with bits [1:0] forced to 0.
  - Writes to 13, 15 or any other number are ignored.
- eret: EXLClr=1 clears SR.EXL on the edge.
  - EXLClr with EXL=0 has no effect.
  - EXLClr together with mtc0 to SR on the same edge: the mtc0 value is written, then EXL is cleared.
- mfc0: DOut is combinational from A1 (12 SR, 13 Cause, 14 EPC, 15 PRID_VALUE, others 0).
  - There is no write-to-read bypass; same-cycle read returns the old value. The hazard unit stalls.
- Nested events: while EXL=1 all new interrupts and exceptions are ignored. ExcCode_M is not latched and not queued.
- HWInt is level: an interrupt still asserted after eret re-enters on the next eligible cycle.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- When defined:
  - Adds input BadAddr_M[31:0] and register 8 (BadVAddr).
  - On an exception entry with ExcCode_M = 4 or 5 and int_req=0, BadVAddr <= BadAddr_M. Otherwise it holds.
  - Reads of A1=8 return BadVAddr. The register is read-only to mtc0.
- When undefined: no BadAddr_M port, and A1=8 reads 0.

Test Plan:
- Reset then read: assert reset=0 mid-cycle, release; A1=12/13/14 -> DOut=0; A1=15 -> 32'h0000_4D4D; IntReq=0.
- Overflow exception: SR=0, ExcCode_M=12, PC_M=32'h0000_3010, BD_M=0 for one cycle -> IntReq=1 that cycle; next cycle EXL=1, Cause[6:2]=12, EPC=32'h0000_3010, IntReq=0 despite ExcCode_M held at 12.
- Delay-slot entry: ExcCode_M=4, PC_M=32'h0000_3024, BD_M=1 -> EPC=32'h0000_3020, Cause[31]=1, Cause[6:2]=4 (with CP0_BADVADDR_EN: BadAddr_M=32'h0000_0003 -> reg 8 reads 3).
- Interrupt priority and masking:
  - SR written 32'h0000_0401 via mtc0, HWInt=6'b000001 -> IntReq=1, Cause[6:2]=0 even with ExcCode_M=5 simultaneous.
  - HWInt=6'b000010 with the same SR -> IntReq=0; Cause[15:10]=6'b000010.
- mtc0 suppressed by entry: WE=1, A2=14, DIn=32'h1234_5677 in the same cycle as ExcCode_M=12 -> EPC holds the faulting PC, not the write data; a later lone write gives EPC=32'h1234_5674.
- eret and re-entry: with EXL=1 and HWInt held enabled, pulse EXLClr -> EXL=0 on that edge; IntReq=1 the following cycle; second entry recorded.

Source files
------------

// File: rtl/cp0_exc_handler_if.sv
// Pipeline-side bus of the CP0 exception sink: mfc0/mtc0/eret, memory-stage exception info, interrupts.
// Optional CP0_BADVADDR_EN adds the BadAddr_M faulting-address input.
interface cp0_exc_handler_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;
`ifdef CP0_BADVADDR_EN
    logic [31:0] BadAddr_M;
`endif

    modport master (
`ifdef CP0_BADVADDR_EN
        output BadAddr_M,
`endif
        output A1, A2, DIn, WE, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
`ifdef CP0_BADVADDR_EN
        input  BadAddr_M,
`endif
        input  A1, A2, DIn, WE, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_exc_handler.sv
// CP0 exception/interrupt sink: SR/Cause/EPC/PRId, interrupt-over-exception arbitration, mfc0/mtc0/eret.
// Define CP0_BADVADDR_EN to add BadVAddr (reg 8), captured on AdEL/AdES entry.
module cp0_exc_handler #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4D4D
) (
    input  logic                     clk,
    input  logic                     reset,
    cp0_exc_handler_if.slave         bus
);
    localparam int HWINT_W = 6;

    logic [HWINT_W-1:0] r_im;
    logic               r_exl;
    logic               r_ie;
    logic               r_cause_bd;
    logic [HWINT_W-1:0] r_cause_ip;
    logic [4:0]         r_cause_exc;
    logic [31:0]        r_epc;
`ifdef CP0_BADVADDR_EN
    logic [31:0]        r_badvaddr;
`endif

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_entry;
    logic [31:0] w_pc_al;
    logic [31:0] w_epc_entry;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_int_req   = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req   = (bus.ExcCode_M != 5'd0) & ~r_exl;
    assign w_entry     = w_int_req | w_exc_req;
    assign w_pc_al     = bus.PC_M & ~32'h3;
    assign w_epc_entry = bus.BD_M ? (w_pc_al - 32'd4) : w_pc_al;

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

    assign bus.IntReq = w_entry;
    assign bus.EPC    = r_epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im        <= '0;
            r_exl       <= 1'b0;
            r_ie        <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
`ifdef CP0_BADVADDR_EN
            r_badvaddr  <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout; the later EXLClr assignment overrides an mtc0 write of EXL on the same edge.
            r_cause_ip <= bus.HWInt;
            if (w_entry) begin
                r_exl       <= 1'b1;
                r_cause_exc <= w_int_req ? 5'd0 : bus.ExcCode_M;
                r_cause_bd  <= bus.BD_M;
                r_epc       <= w_epc_entry;
`ifdef CP0_BADVADDR_EN
                if (!w_int_req && (bus.ExcCode_M == 5'd4 || bus.ExcCode_M == 5'd5))
                    r_badvaddr <= bus.BadAddr_M;
`endif
            end else begin
                if (bus.WE && bus.A2 == 5'd12) begin
                    r_im  <= bus.DIn[15:10];
                    r_exl <= bus.DIn[1];
                    r_ie  <= bus.DIn[0];
                end
                if (bus.WE && bus.A2 == 5'd14)
                    r_epc <= bus.DIn & ~32'h3;
                if (bus.EXLClr)
                    r_exl <= 1'b0;
            end
        end
    end

    // NOTE: default first so every A1 value drives DOut and no latch is inferred.
    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd12:   bus.DOut = w_sr;
            5'd13:   bus.DOut = w_cause;
            5'd14:   bus.DOut = r_epc;
            5'd15:   bus.DOut = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
            5'd8:    bus.DOut = r_badvaddr;
`endif
            default: bus.DOut = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc_handler.sv
// Directed-vector bench for cp0_exc_handler: reset, exception/interrupt entry, masking, mtc0 rules, eret re-entry.
module tb_cp0_exc_handler;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    cp0_exc_handler_if bus();

    cp0_exc_handler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        check(tag, bus.DOut, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, bus.IntReq}, {31'd0, exp});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.WE  = 1'b1;
        bus.A2  = a;
        bus.DIn = d;
        tick();
        bus.WE  = 1'b0;
    endtask

    task automatic eret();
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        bus.A1        = 5'd0;
        bus.A2        = 5'd0;
        bus.DIn       = 32'd0;
        bus.WE        = 1'b0;
        bus.PC_M      = 32'd0;
        bus.BD_M      = 1'b0;
        bus.ExcCode_M = 5'd0;
        bus.HWInt     = 6'd0;
        bus.EXLClr    = 1'b0;
`ifdef CP0_BADVADDR_EN
        bus.BadAddr_M = 32'd0;
`endif
        #5 reset = 1'b1;
        tick();

        // Dirty the registers, then assert reset mid-cycle
        mtc0(5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'h0000_0ABC);
        bus.HWInt = 6'b000001;
        irq_chk("pre_reset_irq", 1'b1);
        #5 reset = 1'b0;
        irq_chk("rst_irq", 1'b0);
        check("rst_epc_port", bus.EPC, 32'd0);
        rd_chk("rst_sr", 5'd12, 32'd0);
        rd_chk("rst_cause", 5'd13, 32'd0);
        rd_chk("rst_epc", 5'd14, 32'd0);
        rd_chk("rst_prid", 5'd15, 32'h0000_4D4D);
        rd_chk("rst_r8", 5'd8, 32'd0);
        bus.HWInt = 6'd0;
        #3 reset = 1'b1;
        tick();

        // Overflow exception, not in delay slot
        bus.ExcCode_M = 5'd12;
        bus.PC_M      = 32'h0000_3010;
        bus.BD_M      = 1'b0;
        irq_chk("ov_irq", 1'b1);
        tick();
        irq_chk("ov_irq_held_exl", 1'b0);
        rd_chk("ov_sr", 5'd12, 32'h0000_0002);
        rd_chk("ov_cause", 5'd13, 32'h0000_0030);
        rd_chk("ov_epc", 5'd14, 32'h0000_3010);
        check("ov_epc_port", bus.EPC, 32'h0000_3010);
        bus.ExcCode_M = 5'd0;
        eret();
        rd_chk("ov_eret_sr", 5'd12, 32'd0);

        // AdEL in a branch delay slot
        bus.ExcCode_M = 5'd4;
        bus.PC_M      = 32'h0000_3024;
        bus.BD_M      = 1'b1;
`ifdef CP0_BADVADDR_EN
        bus.BadAddr_M = 32'h0000_0003;
`endif
        tick();
        bus.ExcCode_M = 5'd0;
        bus.BD_M      = 1'b0;
        rd_chk("bd_cause", 5'd13, 32'h8000_0010);
        rd_chk("bd_epc", 5'd14, 32'h0000_3020);
`ifdef CP0_BADVADDR_EN
        rd_chk("bd_badvaddr", 5'd8, 32'h0000_0003);
        bus.BadAddr_M = 32'hDEAD_BEEC;
`endif
        eret();

        // Interrupt beats a simultaneous exception
        mtc0(5'd12, 32'h0000_0401);
        rd_chk("pri_sr_wr", 5'd12, 32'h0000_0401);
        bus.HWInt     = 6'b000001;
        bus.ExcCode_M = 5'd5;
        irq_chk("pri_irq", 1'b1);
        tick();
        bus.ExcCode_M = 5'd0;
        irq_chk("pri_irq_exl", 1'b0);
        rd_chk("pri_cause", 5'd13, 32'h0000_0400);
        rd_chk("pri_sr", 5'd12, 32'h0000_0403);
        rd_chk("pri_epc", 5'd14, 32'h0000_3024);
`ifdef CP0_BADVADDR_EN
        rd_chk("pri_badvaddr_hold", 5'd8, 32'h0000_0003);
`endif

        // Masked line, then IE=0 masking
        bus.HWInt = 6'b000010;
        eret();
        irq_chk("mask_im_irq", 1'b0);
        rd_chk("mask_cause_ip", 5'd13, 32'h0000_0800);
        mtc0(5'd12, 32'h0000_0400);
        bus.HWInt = 6'b000001;
        irq_chk("mask_ie_irq", 1'b0);
        bus.HWInt = 6'd0;

        // mtc0 to EPC on an entry edge is suppressed
        bus.ExcCode_M = 5'd12;
        bus.PC_M      = 32'h0000_3010;
        bus.WE        = 1'b1;
        bus.A2        = 5'd14;
        bus.DIn       = 32'h1234_5677;
        irq_chk("sup_irq", 1'b1);
        tick();
        bus.WE        = 1'b0;
        bus.ExcCode_M = 5'd0;
        rd_chk("sup_epc", 5'd14, 32'h0000_3010);
        eret();

        // Lone EPC write, with same-cycle read returning the old value
        bus.WE  = 1'b1;
        bus.A2  = 5'd14;
        bus.DIn = 32'h1234_5677;
        rd_chk("nobypass_epc", 5'd14, 32'h0000_3010);
        tick();
        bus.WE = 1'b0;
        rd_chk("wr_epc", 5'd14, 32'h1234_5674);
        check("wr_epc_port", bus.EPC, 32'h1234_5674);

        // Read-only and masked-field writes
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd_chk("cause_ro", 5'd13, 32'h0000_0030);
        mtc0(5'd15, 32'd0);
        rd_chk("prid_ro", 5'd15, 32'h0000_4D4D);
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd_chk("sr_fields", 5'd12, 32'h0000_FC03);

        // mtc0 SR and eret on the same edge: write then clear EXL
        bus.WE     = 1'b1;
        bus.A2     = 5'd12;
        bus.DIn    = 32'h0000_0403;
        bus.EXLClr = 1'b1;
        tick();
        bus.WE     = 1'b0;
        bus.EXLClr = 1'b0;
        rd_chk("wr_eret_sr", 5'd12, 32'h0000_0401);
        eret();
        rd_chk("eret_noexl_sr", 5'd12, 32'h0000_0401);

        // eret with the interrupt still asserted re-enters
        bus.PC_M  = 32'h0000_3030;
        bus.HWInt = 6'b000001;
        irq_chk("re1_irq", 1'b1);
        tick();
        rd_chk("re1_epc", 5'd14, 32'h0000_3030);
        irq_chk("re1_irq_exl", 1'b0);
        bus.PC_M   = 32'h0000_3040;
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        rd_chk("re_eret_sr", 5'd12, 32'h0000_0401);
        irq_chk("re2_irq", 1'b1);
        tick();
        rd_chk("re2_epc", 5'd14, 32'h0000_3040);
        rd_chk("re2_sr", 5'd12, 32'h0000_0403);
        rd_chk("re2_cause", 5'd13, 32'h0000_0400);
        irq_chk("re2_irq_exl", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
